// File: rtl/simple_cpu_fetch_exec.sv
// Three-state fetch/decode/execute controller for the Simple CPU (PC, IR, ACC, carry).
// Optional feature macro: SCPU_HALT_EN (a self-targeting JMP freezes the core in EXECUTE).
module simple_cpu_fetch_exec #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  carry,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [1:0]            state,
    output logic                  halted
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_JZ  = 2'b11;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;
    logic [DATA_WIDTH-1:0] r_acc, w_acc_nxt;
    logic                  r_carry, w_carry_nxt;
    logic                  r_halted, w_halted_nxt;

    logic [1:0]            w_opcode;
    logic [DATA_WIDTH-3:0] w_operand;
    logic [DATA_WIDTH-1:0] w_addend;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_opcode  = r_ir[DATA_WIDTH-1:DATA_WIDTH-2];
    assign w_operand = r_ir[DATA_WIDTH-3:0];
    assign w_addend  = (w_opcode == OP_INC) ? DATA_WIDTH'(1) : DATA_WIDTH'(w_operand);
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};

`ifdef SCPU_HALT_EN
    logic w_self_jmp;
    // PC already points past the JMP during EXECUTE, so the JMP's own address is PC-1.
    assign w_self_jmp = (ADDR_WIDTH'(w_operand) == (r_pc - ADDR_WIDTH'(1)));
`endif

    // Next-state and datapath update for the fetch/decode/execute sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_acc_nxt    = r_acc;
        w_carry_nxt  = r_carry;
        w_halted_nxt = r_halted;
        case (r_state)
            ST_FETCH: begin
                w_ir_nxt    = instruction;
                w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (r_halted) begin
                    w_state_nxt = ST_EXECUTE;
                end else begin
                    w_state_nxt = ST_FETCH;
                    case (w_opcode)
                        OP_ADD, OP_INC: begin
                            w_acc_nxt   = w_sum[DATA_WIDTH-1:0];
                            w_carry_nxt = w_sum[DATA_WIDTH];
                        end
                        OP_JMP: begin
                            w_pc_nxt = ADDR_WIDTH'(w_operand);
`ifdef SCPU_HALT_EN
                            if (w_self_jmp) begin
                                w_halted_nxt = 1'b1;
                                w_state_nxt  = ST_EXECUTE;
                            end else begin
                                w_halted_nxt = r_halted;
                            end
`endif
                        end
                        OP_JZ: begin
                            if (r_acc == DATA_WIDTH'(0)) begin
                                w_pc_nxt = ADDR_WIDTH'(w_operand);
                            end else begin
                                w_pc_nxt = r_pc;
                            end
                        end
                        default: begin
                            w_pc_nxt = r_pc;
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
`ifndef SCPU_HALT_EN
        w_halted_nxt = 1'b0;
`endif
    end

    // Architectural registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= ADDR_WIDTH'(0);
            r_ir     <= DATA_WIDTH'(0);
            r_acc    <= DATA_WIDTH'(0);
            r_carry  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_acc    <= w_acc_nxt;
            r_carry  <= w_carry_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    assign address = r_pc;
    assign pc      = r_pc;
    assign ir      = r_ir;
    assign acc     = r_acc;
    assign carry   = r_carry;
    assign state   = r_state;
    assign halted  = r_halted;

endmodule

// File: tb/tb_simple_cpu_fetch_exec.sv
// Self-checking bench for simple_cpu_fetch_exec: vector table of short programs plus
// hand-written sequences (cycle trace, PC wrap, async reset, halt), scoreboard-compared.
module tb_simple_cpu_fetch_exec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] address;
    logic [7:0] instruction;
    logic [7:0] acc;
    logic       carry;
    logic [5:0] pc;
    logic [7:0] ir;
    logic [1:0] state;
    logic       halted;

    logic [7:0] rom [64];

    always #5 clk = ~clk;

    assign instruction = rom[address];

    simple_cpu_fetch_exec #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .instruction (instruction),
        .acc         (acc),
        .carry       (carry),
        .pc          (pc),
        .ir          (ir),
        .state       (state),
        .halted      (halted)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic [63:0] prog;
        int          ninstr;
        logic [7:0]  acc;
        logic        carry;
        logic [5:0]  pc;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic [5:0] pc;
        logic [7:0] acc;
    } trace_t;

    sb_t    sbq[$];
    vec_t   vecs[9];
    trace_t trace[9];
    int     checks   = 0;
    int     failures = 0;

    task automatic sb_push(input string n, input logic [31:0] e);
        sb_t t;
        t.name = n;
        t.exp  = e;
        sbq.push_back(t);
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t t;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=%0h", act);
        end else begin
            t = sbq.pop_front();
            if (act !== t.exp) begin
                failures++;
                $display("FAIL %s actual=%0h expected=%0h", t.name, act, t.exp);
            end
        end
    endtask

    task automatic load_prog(input logic [63:0] p);
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        for (int i = 0; i < 8; i++) rom[i] = p[63-8*i -: 8];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;

        vecs[0] = '{"add3",          64'h03000000_00000000, 1, 8'h03, 1'b0, 6'd1};
        vecs[1] = '{"add_jmp_loop",  64'h03800000_00000000, 4, 8'h06, 1'b0, 6'd0};
        vecs[2] = '{"add_carry",     64'h3F3F3F3F_02030000, 6, 8'h01, 1'b1, 6'd6};
        vecs[3] = '{"inc_clr_carry", 64'h3F3F3F3F_02034000, 7, 8'h02, 1'b0, 6'd7};
        vecs[4] = '{"jz_taken",      64'h0000C500_00000000, 3, 8'h00, 1'b0, 6'd5};
        vecs[5] = '{"jz_untaken",    64'h0001C500_00000000, 3, 8'h01, 1'b0, 6'd3};
        vecs[6] = '{"jmp_keep_c",    64'h3F3F3F3F_02038A00, 7, 8'h01, 1'b1, 6'd10};
        vecs[7] = '{"jz_nt_keep_c",  64'h3F3F3F3F_0203C000, 7, 8'h01, 1'b1, 6'd7};
        vecs[8] = '{"inc_wrap_jz",   64'h3F3F3F3F_024040C9, 8, 8'h00, 1'b1, 6'd9};

        trace[0] = '{2'b01, 6'd1, 8'd0};
        trace[1] = '{2'b10, 6'd1, 8'd0};
        trace[2] = '{2'b00, 6'd1, 8'd3};
        trace[3] = '{2'b01, 6'd2, 8'd3};
        trace[4] = '{2'b10, 6'd2, 8'd3};
        trace[5] = '{2'b00, 6'd0, 8'd3};
        trace[6] = '{2'b01, 6'd1, 8'd3};
        trace[7] = '{2'b10, 6'd1, 8'd3};
        trace[8] = '{2'b00, 6'd1, 8'd6};

        // reset state, checked while rst_n is still low
        repeat (2) @(negedge clk);
        sb_push("rst_acc", 32'h0);   sb_push("rst_pc", 32'h0);   sb_push("rst_ir", 32'h0);
        sb_push("rst_carry", 32'h0); sb_push("rst_state", 32'h0); sb_push("rst_halted", 32'h0);
        sb_push("rst_address", 32'h0);
        sb_check(acc); sb_check(pc); sb_check(ir);
        sb_check(carry); sb_check(state); sb_check(halted); sb_check(address);

        // table-driven programs
        for (int v = 0; v < 9; v++) begin
            load_prog(vecs[v].prog);
            do_reset();
            sb_push({vecs[v].name, "_acc"},   32'(vecs[v].acc));
            sb_push({vecs[v].name, "_carry"}, 32'(vecs[v].carry));
            sb_push({vecs[v].name, "_pc"},    32'(vecs[v].pc));
            sb_push({vecs[v].name, "_addr"},  32'(vecs[v].pc));
            sb_push({vecs[v].name, "_state"}, 32'h0);
            step(3 * vecs[v].ninstr);
            sb_check(acc); sb_check(carry); sb_check(pc); sb_check(address); sb_check(state);
        end

        // cycle-by-cycle trace of ADD 3 / JMP 0
        load_prog(64'h03800000_00000000);
        do_reset();
        for (int c = 0; c < 9; c++) begin
            sb_push($sformatf("trace%0d_state", c + 1), 32'(trace[c].st));
            sb_push($sformatf("trace%0d_pc", c + 1),    32'(trace[c].pc));
            sb_push($sformatf("trace%0d_acc", c + 1),   32'(trace[c].acc));
        end
        for (int c = 0; c < 9; c++) begin
            step(1);
            sb_check(state); sb_check(pc); sb_check(acc);
        end

        // PC wrap: JMP 63, INC at 63, next fetch from 0
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        rom[0]  = 8'hBF;
        rom[63] = 8'h40;
        do_reset();
        sb_push("wrap_pc63", 32'd63);
        step(3);
        sb_check(pc);
        sb_push("wrap_pc0", 32'd0); sb_push("wrap_addr0", 32'd0); sb_push("wrap_ir", 32'h40);
        step(1);
        sb_check(pc); sb_check(address); sb_check(ir);
        sb_push("wrap_acc", 32'h01); sb_push("wrap_refetch_ir", 32'hBF); sb_push("wrap_refetch_pc", 32'd1);
        step(2);
        sb_check(acc);
        step(1);
        sb_check(ir); sb_check(pc);

        // asynchronous reset during DECODE with acc=9
        load_prog(64'h09000000_00000000);
        do_reset();
        step(4);
        sb_push("pre_rst_acc", 32'h09); sb_push("pre_rst_state", 32'h1);
        sb_check(acc); sb_check(state);
        #1 rst_n = 1'b0;
        #1;
        sb_push("arst_acc", 32'h0); sb_push("arst_pc", 32'h0); sb_push("arst_ir", 32'h0);
        sb_push("arst_carry", 32'h0); sb_push("arst_state", 32'h0);
        sb_check(acc); sb_check(pc); sb_check(ir); sb_check(carry); sb_check(state);
        @(negedge clk);
        rst_n = 1'b1;
        sb_push("post_rst_ir", 32'h09); sb_push("post_rst_pc", 32'h1);
        step(1);
        sb_check(ir); sb_check(pc);

        // self-targeting JMP 2 at address 2
        load_prog(64'h05008200_00000000);
        do_reset();
        step(9);
        for (int i = 1; i <= 20; i++) begin
`ifdef SCPU_HALT_EN
            sb_push($sformatf("halt%0d_halted", i), 32'h1);
            sb_push($sformatf("halt%0d_state", i),  32'h2);
            sb_push($sformatf("halt%0d_addr", i),   32'd2);
`else
            sb_push($sformatf("loop%0d_halted", i), 32'h0);
            sb_push($sformatf("loop%0d_state", i),  ((i % 3) == 2) ? 32'h2 : 32'(i % 3));
            sb_push($sformatf("loop%0d_addr", i),   ((i % 3) == 0) ? 32'd2 : 32'd3);
`endif
            sb_push($sformatf("selfjmp%0d_acc", i), 32'h05);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1);
            sb_check(halted); sb_check(state); sb_check(address); sb_check(acc);
        end

        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_cpu_fetch_exec.md
# simple_cpu_fetch_exec

Fetch/decode/execute controller for the Simple CPU. It drives the address into the asynchronous instruction ROM and consumes the returned instruction byte. It sequences a three-state FSM, holds the program counter (PC), instruction register (IR) and accumulator (ACC), and executes the 2-bit-opcode / 6-bit-operand instruction set stored in the ROM. It sits between the ROM and the CPU top level and is the consumer of the ROM's address/instruction interface.

## Interface
- DATA_WIDTH, 8, instruction and accumulator width; opcode = bits [DATA_WIDTH-1:DATA_WIDTH-2], operand = bits [DATA_WIDTH-3:0]
- ADDR_WIDTH, 6, ROM address width; must equal DATA_WIDTH-2

Ports. One clock; reset is asynchronous and active-low.
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- address  output  ADDR_WIDTH  ROM address; registered, equals PC
- instruction  input  DATA_WIDTH  ROM read data; combinational function of address
- acc  output  DATA_WIDTH  accumulator
- carry  output  1  carry-out of the last ADD/INC
- pc  output  ADDR_WIDTH  program counter
- ir  output  DATA_WIDTH  instruction register
- state  output  2  FSM state: FETCH=00, DECODE=01, EXECUTE=10
- halted  output  1  halt indicator; constant 0 unless SCPU_HALT_EN is defined

## Operation
- Opcodes:
  - 00 ADD imm: ACC <= ACC + zero-extended operand.
  - 01 INC: ACC <= ACC + 1; operand ignored.
  - 10 JMP addr: PC <= operand.
  - 11 JZ addr: if ACC == 0 then PC <= operand, else fall through.
- Reset: PC=0, IR=0, ACC=0, carry=0, state=FETCH, halted=0; address=0.
- FETCH: IR <= instruction (ROM output at address=PC); PC <= PC+1 mod 2^ADDR_WIDTH; next state DECODE.
- DECODE: no architectural update; opcode/operand decoded from IR; next state EXECUTE.
- EXECUTE: apply the opcode; next state FETCH.
- address tracks PC. It is updated from PC in the same edge that updates PC, so address == pc at all times.
- Arithmetic is modulo 2^DATA_WIDTH. carry = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum. carry is updated only by ADD and INC; JMP and JZ leave it unchanged.
- JZ tests ACC as it was at the start of EXECUTE.
- PC wrap: fetch at 63 gives PC=0 (ADDR_WIDTH=6). JMP/JZ targets override the incremented PC.
- Reset mid-instruction (any state): all registers return to reset values immediately (asynchronously). The first FETCH occurs at the first rising edge after rst_n deasserts.

## Timing
- Three cycles per instruction, fixed for every opcode, including taken or untaken JZ.
- The ROM is sampled only at the FETCH edge. instruction must be valid by that edge; it is combinational from the registered address.
- Updates become visible on the outputs the cycle after the edge that performs them:
  - ACC/carry after the EXECUTE edge
  - PC/IR after the FETCH edge
  - PC override after the EXECUTE edge
- First instruction after reset: IR loaded at edge 1, executed at edge 3, second fetch at edge 4.

## Configuration
- SCPU_HALT_EN defined:
  - A JMP whose target equals the address of the JMP itself (operand == PC-1 at EXECUTE) sets halted=1 at the EXECUTE edge.
  - The FSM then stays in EXECUTE. PC, IR, ACC and carry stay frozen, and no further fetches occur.
  - Only rst_n clears halted.
- SCPU_HALT_EN undefined:
  - A self-targeting JMP is an ordinary jump that loops forever through FETCH/DECODE/EXECUTE.
  - halted is tied to 0.

## Test plan
- Reset, then ROM {0: 8'h03 (ADD 3), 1: 8'h80 (JMP 0)} -> acc = 3, 6, 9… every 6 cycles; pc alternates 1,2 / 0; state cycles 00,01,10.
- ACC=8'hFE, then ADD 3 -> acc=8'h01, carry=1; a following INC -> acc=8'h02, carry=0.
- JZ taken and untaken:
  - ACC=0, JZ 5 at address 2 -> pc=5 after EXECUTE.
  - ACC=1 -> pc=3.
  - Both paths take exactly 3 cycles.
- PC wrap: INC at address 63 -> pc=0 after FETCH, next fetch reads address 0.
- Assert rst_n low during DECODE with acc=9 -> acc, pc, ir, carry = 0 and state=FETCH immediately, without waiting for a clock edge.
- SCPU_HALT_EN: 8'h82 (JMP 2) at address 2 -> halted=1 after EXECUTE; address stays 2 and acc is unchanged for 20 cycles. Without the macro: halted=0 and state keeps cycling.
